cc_flag_unit: RTL and testbench
===============================

Name: cc_flag_unit

Overview:
Producer side of the pipeline's condition-code path. Holds the architectural NZCV flags and drives them to the ID-stage condition evaluator. Merges flag writes from the EX stage, both single-cycle ALU results and multi-cycle flag writers such as multiply. Forwards in-flight results with zero latency and stalls ID while a multi-cycle flag result is outstanding.

Parameters:
MC_TIMEOUT, 16, max cycles a multi-cycle writer may stay outstanding before being abandoned (>=2)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX-stage instruction valid
ex_s  in  1  EX instruction sets flags (S bit)
ex_mask  in  4  per-flag write enable, [3]=N [2]=Z [1]=C [0]=V
ex_flags  in  4  single-cycle ALU flags, same bit order
ex_flush  in  1  squash the EX instruction this cycle
mc_start  in  1  EX flag writer is multi-cycle; flags arrive later on mc_flags
mc_done  in  1  multi-cycle result valid this cycle
mc_flags  in  4  multi-cycle result flags
id_valid  in  1  ID stage holds an instruction
id_ci  in  4  ID condition field
cc  out  4  flags to condition evaluator, NZCV, forwarded
cc_stall  out  1  hold ID/IF this cycle
mc_busy  out  1  multi-cycle writer outstanding
err  out  1  sticky protocol/timeout error

Behaviour:
- State: cc_reg[3:0], FSM {IDLE, WAIT_MC}, latched mask mc_mask[3:0], cycle counter mc_cnt, err.
- Reset (async, rst_n=0): cc_reg=0000, IDLE, mc_mask=0, mc_cnt=0, err=0. Outputs: cc=0000, cc_stall=0, mc_busy=0, err=0. Reset mid-WAIT_MC discards the pending writer.
- merge(old,new,m) = (new & m) | (old & ~m), bitwise.
- The single-cycle write condition sc_wr = ex_valid & ex_s & ~ex_flush & ~mc_start & IDLE.
- IDLE:
  - If sc_wr: cc = merge(cc_reg, ex_flags, ex_mask) combinationally (0-cycle forward). cc_reg takes that value at the next edge.
  - Otherwise cc = cc_reg.
  - ex_valid & ex_s & mc_start & ~ex_flush: latch mc_mask=ex_mask, mc_cnt=0, go to WAIT_MC. cc_reg is unchanged.
  - mc_done in IDLE is ignored and sets err.
- WAIT_MC:
  - mc_busy=1.
  - If mc_done: cc = merge(cc_reg, mc_flags, mc_mask) that cycle. Commit at the edge, go to IDLE. cc_stall=0 that cycle.
  - Else: cc = cc_reg. cc_stall = id_valid & (id_ci != 1110) & (id_ci != 1111). AL and NV never stall.
  - mc_cnt increments each cycle without mc_done. When mc_cnt == MC_TIMEOUT-1 and no mc_done: go to IDLE, err=1, cc_reg unchanged.
  - Any ex_s write or mc_start arriving in WAIT_MC is ignored and sets err. Upstream guarantees EX is held.
  - ex_flush does not cancel the pending writer, because it is older than the flushed instruction.
- err is sticky; only reset clears it.
- Flag bits with mask=0 keep their cc_reg value exactly.
- mc_cnt width is clog2(MC_TIMEOUT).

Optional Feature:
CC_SPSR_EN: adds inputs spsr_save (1), spsr_restore (1) and output spsr (4), a saved-flags register (reset 0000).
- spsr_save: spsr takes the forwarded cc value (including the same-cycle write) at the edge.
- spsr_restore: cc_reg takes spsr at the edge. It overrides any same-cycle ex/mc write, forces IDLE and clears mc_cnt without setting err. cc shows spsr combinationally that cycle.
- Save and restore in the same cycle swap the two registers.
- Without the macro: the ports are absent, and the logic and registers are not generated.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT_MC with stall active -> cc=0000, cc_stall=0, mc_busy=0, err=0 immediately (async).
- Single write: cc_reg=0000, ex_valid=ex_s=1, ex_mask=1111, ex_flags=0100 -> cc=0100 same cycle, cc_reg=0100 after the edge. Repeat with ex_flush=1 -> cc stays 0000.
- Partial mask: cc_reg=1010, ex_mask=1100, ex_flags=0101 -> cc=0110.
- Multi-cycle: mc_start with mask 1111, id_valid=1, id_ci=0000. mc_done=1, mc_flags=0100 on the 3rd WAIT_MC cycle -> cc_stall=1 for 2 cycles, 0 on the done cycle with cc=0100. id_ci=1110 -> cc_stall=0 throughout.
- Timeout (MC_TIMEOUT=4): mc_start, never mc_done -> mc_busy=1 for 4 cycles then 0, err=1, cc unchanged. A stray mc_done in IDLE afterward is ignored.
- CC_SPSR_EN: cc_reg=1001, spsr_save, then ex write 0000, then spsr_restore during WAIT_MC -> cc=1001, IDLE, err=0.

Source files
------------

// File: rtl/cc_flag_unit.sv
// NZCV condition-code producer: merges EX-stage flag writes, forwards them with zero latency,
// and stalls ID while a multi-cycle flag writer is outstanding. Optional saved-flags register under CC_SPSR_EN.
module cc_flag_unit #(
  parameter int unsigned MC_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ex_valid,
  input  logic       ex_s,
  input  logic [3:0] ex_mask,
  input  logic [3:0] ex_flags,
  input  logic       ex_flush,
  input  logic       mc_start,
  input  logic       mc_done,
  input  logic [3:0] mc_flags,
  input  logic       id_valid,
  input  logic [3:0] id_ci,
`ifdef CC_SPSR_EN
  input  logic       spsr_save,
  input  logic       spsr_restore,
  output logic [3:0] spsr,
`endif
  output logic [3:0] cc,
  output logic       cc_stall,
  output logic       mc_busy,
  output logic       err
);

  localparam int unsigned CNT_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_MC} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cc_reg_q, cc_reg_d;
  logic [3:0]       mc_mask_q, mc_mask_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic             err_q, err_d;
  logic [3:0]       cc_fwd;
  logic [3:0]       cc_out;
  logic             stall_c;
  logic             sc_wr;
  logic             mc_go;
  logic             proto_err;
  logic             tmo;
  logic             restore;

  function automatic logic [3:0] merge(input logic [3:0] old_v, input logic [3:0] new_v,
                                       input logic [3:0] m);
    return (new_v & m) | (old_v & ~m);
  endfunction

`ifdef CC_SPSR_EN
  logic [3:0] spsr_q, spsr_d;
  assign restore = spsr_restore;
`else
  assign restore = 1'b0;
`endif

  assign sc_wr = ex_valid & ex_s & ~ex_flush & ~mc_start & (state_q == IDLE);
  assign mc_go = ex_valid & ex_s & mc_start & ~ex_flush;

  // Next-state, forwarding and error detection
  always_comb begin
    state_d   = state_q;
    cc_reg_d  = cc_reg_q;
    mc_mask_d = mc_mask_q;
    mc_cnt_d  = mc_cnt_q;
    cc_fwd    = cc_reg_q;
    stall_c   = 1'b0;
    proto_err = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sc_wr) begin
          cc_fwd   = merge(cc_reg_q, ex_flags, ex_mask);
          cc_reg_d = cc_fwd;
        end
        if (mc_go) begin
          mc_mask_d = ex_mask;
          mc_cnt_d  = '0;
          state_d   = WAIT_MC;
        end
        if (mc_done) proto_err = 1'b1;
      end
      WAIT_MC: begin
        // EX is held upstream; any new flag writer here is a protocol violation
        if (ex_valid & ~ex_flush & (ex_s | mc_start)) proto_err = 1'b1;
        if (mc_done) begin
          cc_fwd   = merge(cc_reg_q, mc_flags, mc_mask_q);
          cc_reg_d = cc_fwd;
          state_d  = IDLE;
        end else begin
          stall_c = id_valid & (id_ci != 4'b1110) & (id_ci != 4'b1111);
          if (mc_cnt_q == CNT_LAST) begin
            tmo     = 1'b1;
            state_d = IDLE;
          end else begin
            mc_cnt_d = mc_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cc_out = cc_fwd;
`ifdef CC_SPSR_EN
    spsr_d = spsr_save ? cc_fwd : spsr_q;
`endif
    // Restore overrides any same-cycle write and abandons a pending writer silently
    if (restore) begin
`ifdef CC_SPSR_EN
      cc_reg_d = spsr_q;
      cc_out   = spsr_q;
`endif
      state_d  = IDLE;
      mc_cnt_d = '0;
      stall_c  = 1'b0;
    end
    err_d = err_q | proto_err | (tmo & ~restore);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cc_reg_q  <= 4'b0000;
      mc_mask_q <= 4'b0000;
      mc_cnt_q  <= '0;
      err_q     <= 1'b0;
`ifdef CC_SPSR_EN
      spsr_q    <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      cc_reg_q  <= cc_reg_d;
      mc_mask_q <= mc_mask_d;
      mc_cnt_q  <= mc_cnt_d;
      err_q     <= err_d;
`ifdef CC_SPSR_EN
      spsr_q    <= spsr_d;
`endif
    end
  end

  assign cc       = cc_out;
  assign cc_stall = stall_c;
  assign mc_busy  = (state_q == WAIT_MC);
  assign err      = err_q;
`ifdef CC_SPSR_EN
  assign spsr     = spsr_q;
`endif

endmodule

// File: tb/tb_cc_flag_unit.sv
// Bench for cc_flag_unit: directed vector table, hand-written corner sequences and
// randomized traffic against a behavioural flag model. SPSR sequence runs when CC_SPSR_EN is defined.
module tb_cc_flag_unit;

  localparam int unsigned T = 4;

  typedef struct {
    logic       ev, es;
    logic [3:0] em, ef;
    logic       fl, ms, md;
    logic [3:0] mf;
    logic       iv;
    logic [3:0] ic;
    logic [3:0] xcc;
    logic       xst, xbusy, xerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ex_valid = 1'b0, ex_s = 1'b0, ex_flush = 1'b0, mc_start = 1'b0, mc_done = 1'b0;
  logic [3:0] ex_mask = 4'h0, ex_flags = 4'h0, mc_flags = 4'h0, id_ci = 4'h0;
  logic       id_valid = 1'b0;
  logic [3:0] cc;
  logic       cc_stall, mc_busy, err;
`ifdef CC_SPSR_EN
  logic       spsr_save = 1'b0, spsr_restore = 1'b0;
  logic [3:0] spsr;
`endif

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model state
  logic [3:0] m_cc, m_mask;
  bit         m_busy, m_err;
  int         m_cnt;

  cc_flag_unit #(.MC_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_s(ex_s), .ex_mask(ex_mask), .ex_flags(ex_flags),
    .ex_flush(ex_flush), .mc_start(mc_start), .mc_done(mc_done), .mc_flags(mc_flags),
    .id_valid(id_valid), .id_ci(id_ci),
`ifdef CC_SPSR_EN
    .spsr_save(spsr_save), .spsr_restore(spsr_restore), .spsr(spsr),
`endif
    .cc(cc), .cc_stall(cc_stall), .mc_busy(mc_busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic ev, es, input logic [3:0] em, ef, input logic fl, ms, md,
                              input logic [3:0] mf, input logic iv, input logic [3:0] ic,
                              input logic [3:0] xcc, input logic xst, xbusy, xerr);
    vec_t v;
    v.ev = ev; v.es = es; v.em = em; v.ef = ef; v.fl = fl; v.ms = ms; v.md = md;
    v.mf = mf; v.iv = iv; v.ic = ic; v.xcc = xcc; v.xst = xst; v.xbusy = xbusy; v.xerr = xerr;
    return v;
  endfunction

  task automatic model_reset();
    m_cc = 4'h0; m_mask = 4'h0; m_busy = 0; m_err = 0; m_cnt = 0;
  endtask

  // Expected combinational outputs from the model and the current inputs
  task automatic model_exp(output logic [3:0] ecc, output logic est);
    ecc = m_cc;
    est = 1'b0;
    if (!m_busy) begin
      if (ex_valid && ex_s && !ex_flush && !mc_start)
        ecc = (ex_flags & ex_mask) | (m_cc & ~ex_mask);
    end else if (mc_done) begin
      ecc = (mc_flags & m_mask) | (m_cc & ~m_mask);
    end else begin
      est = id_valid && (id_ci < 4'd14);
    end
  endtask

  task automatic model_step(input logic [3:0] ecc);
    m_cc = ecc;
    if (!m_busy) begin
      if (mc_done) m_err = 1;
      if (ex_valid && ex_s && mc_start && !ex_flush) begin
        m_busy = 1; m_mask = ex_mask; m_cnt = 0;
      end
    end else begin
      if (ex_valid && !ex_flush && (ex_s || mc_start)) m_err = 1;
      if (mc_done) m_busy = 0;
      else if (m_cnt == int'(T) - 1) begin m_busy = 0; m_err = 1; end
      else m_cnt++;
    end
  endtask

  task automatic set_in(input vec_t v);
    ex_valid = v.ev; ex_s = v.es; ex_mask = v.em; ex_flags = v.ef; ex_flush = v.fl;
    mc_start = v.ms; mc_done = v.md; mc_flags = v.mf; id_valid = v.iv; id_ci = v.ic;
  endtask

  task automatic tick(input string tag, input vec_t v, input bit use_exp);
    logic [3:0] ecc;
    logic       est;
    @(negedge clk);
    set_in(v);
    #1;
    model_exp(ecc, est);
    if (use_exp) begin
      chk({tag, ".cc"}, cc, v.xcc);
      chk({tag, ".stall"}, {3'b0, cc_stall}, {3'b0, v.xst});
      chk({tag, ".busy"}, {3'b0, mc_busy}, {3'b0, v.xbusy});
      chk({tag, ".err"}, {3'b0, err}, {3'b0, v.xerr});
    end else begin
      chk({tag, ".cc"}, cc, ecc);
      chk({tag, ".stall"}, {3'b0, cc_stall}, {3'b0, est});
      chk({tag, ".busy"}, {3'b0, mc_busy}, {3'b0, m_busy});
      chk({tag, ".err"}, {3'b0, err}, {3'b0, m_err});
    end
    model_step(ecc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_in(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[$];
  vec_t nop;

  initial begin
    model_reset();
    nop = mk(0,0,4'h0,4'h0,0,0,0,4'h0,0,4'h0, 0,0,0,0);
    #1;
    chk("por.cc", cc, 4'h0);
    chk("por.stall", {3'b0, cc_stall}, 4'h0);
    chk("por.busy", {3'b0, mc_busy}, 4'h0);
    chk("por.err", {3'b0, err}, 4'h0);
    do_reset();

    //          ev es em    ef    fl ms md mf    iv ic    xcc  st bz er
    tbl.push_back(mk(1,1,4'hF,4'h4,1,0,0,4'h0,0,4'h0, 4'h0,0,0,0)); // flushed write
    tbl.push_back(mk(1,1,4'hF,4'h4,0,0,0,4'h0,0,4'h0, 4'h4,0,0,0)); // forwarded write
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,0,4'h0, 4'h4,0,0,0));
    tbl.push_back(mk(1,1,4'hF,4'hA,0,0,0,4'h0,0,4'h0, 4'hA,0,0,0));
    tbl.push_back(mk(1,1,4'hC,4'h5,0,0,0,4'h0,0,4'h0, 4'h6,0,0,0)); // partial mask
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,0,4'h0, 4'h6,0,0,0));
    tbl.push_back(mk(1,1,4'hF,4'h0,0,1,0,4'h0,1,4'h0, 4'h6,0,0,0)); // mc start
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,1,4'h0, 4'h6,1,1,0));
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,1,4'h0, 4'h6,1,1,0));
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,1,4'h4,1,4'h0, 4'h4,0,1,0)); // done
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,1,4'h0, 4'h4,0,0,0));
    tbl.push_back(mk(1,1,4'hF,4'h0,0,1,0,4'h0,1,4'hE, 4'h4,0,0,0)); // AL never stalls
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,1,4'hE, 4'h4,0,1,0));
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,1,4'hF, 4'h4,0,1,0));
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,1,4'h9,1,4'hE, 4'h9,0,1,0));
    tbl.push_back(mk(1,1,4'h3,4'h0,0,1,0,4'h0,0,4'h0, 4'h9,0,0,0)); // partial mc mask
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,1,4'h6,0,4'h0, 4'hA,0,1,0));
    tbl.push_back(mk(0,0,4'h0,4'h0,0,0,0,4'h0,0,4'h0, 4'hA,0,0,0));
    foreach (tbl[i]) tick($sformatf("tbl%0d", i), tbl[i], 1'b1);

    // Timeout: busy for exactly T cycles, then error, cc untouched
    tick("to.start", mk(1,1,4'hF,4'h0,0,1,0,4'h0,0,4'h0, 4'hA,0,0,0), 1'b1);
    for (int i = 0; i < int'(T); i++)
      tick($sformatf("to.w%0d", i), mk(0,0,0,0,0,0,0,0,0,0, 4'hA,0,1,0), 1'b1);
    tick("to.stray", mk(0,0,0,0,0,0,1,4'h5,0,4'h0, 4'hA,0,0,1), 1'b1);
    tick("to.after", mk(0,0,0,0,0,0,0,0,0,0, 4'hA,0,0,1), 1'b1);

    // Async reset asserted mid-WAIT_MC while stalling
    tick("ar.start", mk(1,1,4'hF,4'h0,0,1,0,4'h0,1,4'h0, 4'hA,0,0,1), 1'b1);
    @(negedge clk);
    set_in(mk(0,0,0,0,0,0,0,0,1,4'h0, 0,0,0,0));
    #1;
    chk("ar.pre_stall", {3'b0, cc_stall}, 4'h1);
    rst_n = 1'b0;
    #1;
    chk("ar.cc", cc, 4'h0);
    chk("ar.stall", {3'b0, cc_stall}, 4'h0);
    chk("ar.busy", {3'b0, mc_busy}, 4'h0);
    chk("ar.err", {3'b0, err}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

`ifdef CC_SPSR_EN
    tick("sp.w9", mk(1,1,4'hF,4'h9,0,0,0,4'h0,0,4'h0, 4'h9,0,0,0), 1'b1);
    @(negedge clk);
    set_in(nop);
    spsr_save = 1'b1;
    @(negedge clk);
    spsr_save = 1'b0;
    chk("sp.saved", spsr, 4'h9);
    tick("sp.w0", mk(1,1,4'hF,4'h0,0,0,0,4'h0,0,4'h0, 4'h0,0,0,0), 1'b1);
    tick("sp.mc", mk(1,1,4'hF,4'h0,0,1,0,4'h0,1,4'h0, 4'h0,0,0,0), 1'b1);
    @(negedge clk);
    set_in(mk(0,0,0,0,0,0,0,0,1,4'h0, 0,0,0,0));
    spsr_restore = 1'b1;
    #1;
    chk("sp.rst_cc", cc, 4'h9);
    @(negedge clk);
    spsr_restore = 1'b0;
    #1;
    chk("sp.cc", cc, 4'h9);
    chk("sp.busy", {3'b0, mc_busy}, 4'h0);
    chk("sp.err", {3'b0, err}, 4'h0);
    do_reset();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      vec_t v;
      if (n % 60 == 59) do_reset();
      v = nop;
      v.ev = m_busy ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 3) != 0);
      v.es = $urandom_range(0, 4) != 0;
      v.em = 4'($urandom);
      v.ef = 4'($urandom);
      v.fl = $urandom_range(0, 7) == 0;
      v.ms = $urandom_range(0, 4) == 0;
      v.md = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      v.mf = 4'($urandom);
      v.iv = $urandom_range(0, 1) == 1;
      v.ic = 4'($urandom);
      tick($sformatf("rnd%0d", n), v, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
